// File: rtl/adc_frame_aligner_if.sv
// Bundle of the frame/lane capture signals between the ISERDES front end and the aligner.
// The master side drives enable and captured words; the slave (aligner) returns control and samples.
interface adc_frame_aligner_if #(
    parameter int NUM_CH = 4,
    parameter int LANES  = 2,
    parameter int SER    = 8,
    parameter int BITS   = 14
);
    localparam int SLIP_W = $clog2(2*SER+1);

    logic                          en;
    logic [SER-1:0]                frm_data;
    logic [NUM_CH*LANES*SER-1:0]   lane_data;
    logic                          bitslip;
    logic [NUM_CH*BITS-1:0]        samples_o;
    logic                          sample_valid;
    logic                          locked;
    logic                          align_fail;
    logic [SLIP_W-1:0]             slip_cnt;
    logic [7:0]                    realign_cnt;

    modport master (
        output en, frm_data, lane_data,
        input  bitslip, samples_o, sample_valid, locked, align_fail, slip_cnt, realign_cnt
    );

    modport slave (
        input  en, frm_data, lane_data,
        output bitslip, samples_o, sample_valid, locked, align_fail, slip_cnt, realign_cnt
    );
endinterface

// File: rtl/adc_frame_aligner.sv
// Frame-word aligner for multi-lane ADC capture: searches with a shared bitslip, holds lock
// with a miss tolerance, and assembles interleaved lane bits into registered samples.
module adc_frame_aligner #(
    parameter int             NUM_CH     = 4,
    parameter int             LANES      = 2,
    parameter int             SER        = 8,
    parameter int             BITS       = 14,
    parameter logic [SER-1:0] FRAME_PAT  = 8'hF0,
    parameter int             SLIP_WAIT  = 3,
    parameter int             LOCK_CNT   = 16,
    parameter int             MISS_LIMIT = 4,
    parameter int             TWOS_COMP  = 0
) (
    input  logic               CLKDIV,
    input  logic               cpu_resetn,
    adc_frame_aligner_if.slave bus
);
    localparam int LW      = NUM_CH*LANES*SER;
    localparam int SW      = NUM_CH*BITS;
    localparam int WPL     = BITS/LANES;
    localparam int SLIP_W  = $clog2(2*SER+1);
    localparam int MATCH_W = $clog2(LOCK_CNT+1);
    localparam int MISS_W  = $clog2(MISS_LIMIT+1);
    localparam int WAIT_W  = $clog2(SLIP_WAIT+1);

    localparam logic [SLIP_W-1:0]  SLIP_MAX   = SLIP_W'(2*SER);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT-1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MISS_LIMIT-1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT-1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SLIP, S_WAIT, S_VERIFY, S_LOCKED, S_FAIL
    } state_t;

    state_t              state, state_n;
    logic [SLIP_W-1:0]   slip_q, slip_n;
    logic [MATCH_W-1:0]  match_q, match_n;
    logic [MISS_W-1:0]   miss_q, miss_n;
    logic [WAIT_W-1:0]   wait_q, wait_n;
    logic [7:0]          realign_q, realign_n;
    logic                frame_ok;
    logic [SW-1:0]       samples_p1;
    logic                sample_valid_p1;
    logic                unused_lane_bits;

    // Lane l bit k lands at sample[BITS-1-(k*LANES+(LANES-1-l))]; bits above WPL are padding.
    function automatic logic [SW-1:0] assemble(input logic [LW-1:0] lanes);
        logic [SW-1:0] s;
        s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < WPL; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    s[c*BITS + BITS-1-(k*LANES+(LANES-1-l))] = lanes[(c*LANES+l)*SER + k];
                end
            end
            if (TWOS_COMP != 0) begin
                s[c*BITS + BITS-1] = ~s[c*BITS + BITS-1];
            end
        end
        return s;
    endfunction

    assign frame_ok         = (bus.frm_data == FRAME_PAT);
    assign unused_lane_bits = ^bus.lane_data;

    always_comb begin
        state_n   = state;
        slip_n    = slip_q;
        match_n   = match_q;
        miss_n    = miss_q;
        wait_n    = wait_q;
        realign_n = realign_q;
        if (!bus.en) begin
            state_n = S_IDLE;
            slip_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_CHECK;
                    slip_n  = '0;
                end
                S_CHECK: begin
                    if (frame_ok) begin
                        state_n = S_VERIFY;
                        match_n = MATCH_W'(1);
                    end else if (slip_q >= SLIP_MAX) begin
                        state_n = S_FAIL;
                    end else begin
                        state_n = S_SLIP;
                    end
                end
                S_SLIP: begin
                    slip_n  = slip_q + 1'b1;
                    wait_n  = '0;
                    state_n = S_WAIT;
                end
                // Frame words are ignored while the ISERDES settles after a slip.
                S_WAIT: begin
                    if (wait_q == WAIT_LAST) state_n = S_CHECK;
                    else                     wait_n  = wait_q + 1'b1;
                end
                S_VERIFY: begin
                    if (!frame_ok) begin
                        state_n = S_SLIP;
                        match_n = '0;
                    end else if (match_q == MATCH_LAST) begin
                        state_n = S_LOCKED;
                        miss_n  = '0;
                    end else begin
                        match_n = match_q + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (frame_ok) begin
                        miss_n = '0;
                    end else if (miss_q == MISS_LAST) begin
                        state_n = S_SLIP;
                        miss_n  = '0;
                        slip_n  = '0;
                        if (realign_q != 8'hFF) realign_n = realign_q + 8'd1;
                    end else begin
                        miss_n = miss_q + 1'b1;
                    end
                end
                S_FAIL:  state_n = S_FAIL;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state     <= S_IDLE;
            slip_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            wait_q    <= '0;
            realign_q <= '0;
        end else begin
            state     <= state_n;
            slip_q    <= slip_n;
            match_q   <= match_n;
            miss_q    <= miss_n;
            wait_q    <= wait_n;
            realign_q <= realign_n;
        end
    end

    // Stage p1: assembled samples and their valid flag, one cycle behind lane_data.
    always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            samples_p1      <= '0;
            sample_valid_p1 <= 1'b0;
        end else begin
            samples_p1      <= assemble(bus.lane_data);
            sample_valid_p1 <= bus.en && (state == S_LOCKED);
        end
    end

    assign bus.bitslip      = (state == S_SLIP);
    assign bus.locked       = (state == S_LOCKED);
    assign bus.align_fail   = (state == S_FAIL);
    assign bus.slip_cnt     = slip_q;
    assign bus.realign_cnt  = realign_q;
    assign bus.samples_o    = samples_p1;
    assign bus.sample_valid = sample_valid_p1;
endmodule
